inst_cache_assoc: RTL and testbench
===================================

Name: inst_cache_assoc

Overview:
- Parametrised N-way set-associative instruction cache; successor to the direct-mapped instruction cache, between CPU fetch stage and the 256-bit line memory port.
- Combinational hit path; blocking refill of line-aligned 256-bit lines.
- Per-set round-robin replacement, single-cycle flush, uncached window passthrough.

Parameters:
- WAYS, 2, associativity; legal values 1, 2, 4.
- SETS, 64, number of sets; power of two, 2 or more.
- UNCACHED_MASK, 32'hFFFF_F000, an address is uncached when (addr & mask) == mask.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst_addr_i  in  32  fetch address; bits [1:0] ignored.
- inst_data_o  out  32  fetched word; valid only while inst_valid_o=1.
- inst_valid_o  out  1  hit (cached) or uncached_ack_i (uncached).
- mem_fc  in  1  flush request, one-cycle pulse or level.
- hw_page_fault_o  out  1  fault indication for the current refill.
- uncached_addr_o  out  32  equals inst_addr_i.
- uncached_data_i  in  32  uncached read data.
- uncached_rd_o  out  1  1 when inst_addr_i is uncached.
- uncached_ack_i  in  1  uncached data valid.
- addr_o  out  32  refill address, line-aligned (bits [4:0]=0).
- data_i  in  256  refill line; word k at bits [32k+31:32k].
- rd_o  out  1  refill request; held until ack_i.
- ack_i  in  1  refill done; single-cycle pulse.
- hw_page_fault_i  in  1  qualifies ack_i; line faulted.

Behaviour:
- Reset (rst_n=0, asynchronous): rd_o=0, addr_o=0, all valid bits=0, round-robin pointers=0, FSM=IDLE. Data and tag arrays are not reset.
- Address split: off=[4:0], set=[4+log2(SETS):5], tag=the remaining upper bits.
- Hit: any way w with valid[set][w] and tag[set][w]==tag. inst_valid_o=1 in the same cycle; word = line[w] word off[4:2]. At most one way may match; a second match is a verification error.
- Uncached: hit logic is bypassed. inst_valid_o=uncached_ack_i and inst_data_o=uncached_data_i. A refill is never started for an uncached address.
- FSM IDLE: on a cached miss with mem_fc=0, go to FILL next edge. On that edge:
  - latch addr_o={inst_addr_i[31:5],5'b0};
  - set rd_o=1;
  - latch the victim way: lowest-index invalid way in the set, else rr[set].
- FSM FILL: rd_o stays 1 and addr_o stays stable until ack_i. On ack_i:
  - write data_i into the victim way data array and addr_o's tag into the tag array;
  - valid bit = ~hw_page_fault_i;
  - if the victim was chosen by rr, rr[set] increments modulo WAYS;
  - rd_o=0, addr_o=0, return to IDLE.
- The earliest hit on a refilled line is the cycle after ack_i, giving 2-cycle miss overhead beyond memory latency.
- hw_page_fault_o = rd_o & ack_i & hw_page_fault_i (combinational). A faulted line stays invalid, so re-fetching it re-requests.
- inst_addr_i changing during FILL: the refill still completes into the latched set/way, with no abort. The new address is evaluated in IDLE afterwards.
- mem_fc: clears every valid bit on the edge. If it coincides with ack_i, the line is written but its valid bit ends 0 (flush wins). mem_fc in IDLE suppresses starting a refill that cycle.
- WAYS=1 degenerates to direct-mapped: the victim is always way 0, and rr logic is absent.
- Reset asserted mid-FILL: rd_o drops immediately and any pending ack_i is ignored until rst_n=1.

Optional Feature:
- Macro INST_CACHE_STATS_EN.
- When defined, add outputs hit_count_o[31:0] and miss_count_o[31:0], reset to 0, wrapping at 2^32.
  - hit_count_o increments on each cycle with a cached hit and no change... it increments once per cycle where a cached address hits.
  - miss_count_o increments on each IDLE to FILL transition.
  - Both are cleared by mem_fc.
- When not defined, the ports and counters are absent.

Test Plan:
- Reset then fetch 0x0000_0100: rd_o=1 next cycle with addr_o=0x0000_0100. Ack data word2=0xDEADBEEF, fetch 0x0000_0108 → inst_valid_o=1, data 0xDEADBEEF.
- WAYS=2, SETS=64: fill 0x0000_0000, then 0x0000_0800 (same set 0). Both hit afterwards. Fill 0x0000_1000 → evicts way 0 (0x0000_0000 misses, 0x0000_0800 hits).
- Fetch 0xFFFF_F004 → uncached_rd_o=1, rd_o stays 0. uncached_ack_i=1 with data 0x12345678 → inst_valid_o=1, inst_data_o=0x12345678.
- Refill acked with hw_page_fault_i=1 → hw_page_fault_o=1 that cycle. The next cycle shows a miss again on the same address.
- mem_fc asserted on the same cycle as ack_i → line not valid afterwards. Lines previously valid in other sets also miss.
- Drop rst_n mid-FILL → rd_o=0 and addr_o=0 immediately. After release, the same fetch re-issues rd_o with the aligned addr_o.

Source files
------------

// File: rtl/inst_cache_assoc.sv
// inst_cache_assoc
// N-way set-associative instruction cache between the fetch stage and a
// 256-bit line memory port. Hits are combinational; a miss blocks in FILL
// until the line returns. Replacement is per-set round-robin, preferring
// the lowest invalid way. Addresses inside the uncached window bypass the
// arrays entirely.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   inst_addr_i / inst_data_o / inst_valid_o   fetch side
//   mem_fc                             flush: clears all valid bits
//   hw_page_fault_o                    refill completed with a fault
//   uncached_addr_o/_data_i/_rd_o/_ack_i       uncached passthrough
//   addr_o / data_i / rd_o / ack_i / hw_page_fault_i  line refill port
//
// Optional: define INST_CACHE_STATS_EN to add hit_count_o / miss_count_o.
module inst_cache_assoc #(
    parameter int          WAYS          = 2,
    parameter int          SETS          = 64,
    parameter logic [31:0] UNCACHED_MASK = 32'hFFFF_F000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  inst_addr_i,
    output logic [31:0]  inst_data_o,
    output logic         inst_valid_o,
    input  logic         mem_fc,
    output logic         hw_page_fault_o,
    output logic [31:0]  uncached_addr_o,
    input  logic [31:0]  uncached_data_i,
    output logic         uncached_rd_o,
    input  logic         uncached_ack_i,
    output logic [31:0]  addr_o,
    input  logic [255:0] data_i,
    output logic         rd_o,
    input  logic         ack_i,
    input  logic         hw_page_fault_i
`ifdef INST_CACHE_STATS_EN
    ,
    output logic [31:0]  hit_count_o,
    output logic [31:0]  miss_count_o
`endif
);

    localparam int SB = $clog2(SETS);
    localparam int TW = 32 - 5 - SB;
    localparam int WB = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {IDLE, FILL} state_e;

    state_e                    state_q, state_d;
    logic [31:0]               addr_q, addr_d;
    logic [WB-1:0]             vic_q, vic_d;
    logic                      vic_rr_q, vic_rr_d;
    logic [SETS-1:0][WAYS-1:0] valid_q;
    logic [TW-1:0]             tag_q  [SETS][WAYS];
    logic [255:0]              data_q [SETS][WAYS];

    logic [SB-1:0] set_idx, fill_set;
    logic [TW-1:0] tag_in;
    logic          uncached;
    logic [WAYS-1:0] hit_vec;
    logic [31:0]   hit_word;
    logic          hit;
    logic [WB-1:0] rr_cur;
    logic [WB-1:0] victim;
    logic          victim_by_rr;
    logic          fill_done;

    assign set_idx  = inst_addr_i[5+SB-1:5];
    assign tag_in   = inst_addr_i[31:5+SB];
    assign fill_set = addr_q[5+SB-1:5];
    assign uncached = (inst_addr_i & UNCACHED_MASK) == UNCACHED_MASK;
    assign fill_done = (state_q == FILL) && ack_i;

    // Only misses trigger fills and a flush clears every way, so at most one
    // way can ever match; OR-combining the matching words is therefore safe.
    always_comb begin
        hit_vec  = '0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag_in) begin
                hit_vec[w] = 1'b1;
                hit_word   = hit_word | data_q[set_idx][w][{inst_addr_i[4:2], 5'b0} +: 32];
            end
        end
    end

    assign hit = ~uncached & (|hit_vec);

    // Lowest-index invalid way wins; round-robin only when the set is full.
    always_comb begin
        victim       = rr_cur;
        victim_by_rr = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[set_idx][w]) begin
                victim       = WB'(w);
                victim_by_rr = 1'b0;
            end
        end
    end

    generate
        if (WAYS > 1) begin : g_rr
            logic [SETS-1:0][WB-1:0] rr_q;
            assign rr_cur = rr_q[set_idx];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rr_q <= '0;
                end else if (fill_done && vic_rr_q) begin
                    rr_q[fill_set] <= rr_q[fill_set] + WB'(1);
                end
            end
        end else begin : g_no_rr
            assign rr_cur = '0;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        vic_d    = vic_q;
        vic_rr_d = vic_rr_q;
        case (state_q)
            IDLE: begin
                if (!uncached && !hit && !mem_fc) begin
                    state_d  = FILL;
                    addr_d   = {inst_addr_i[31:5], 5'b0};
                    vic_d    = victim;
                    vic_rr_d = victim_by_rr;
                end
            end
            FILL: begin
                if (ack_i) begin
                    state_d = IDLE;
                    addr_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            vic_q    <= '0;
            vic_rr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            vic_q    <= vic_d;
            vic_rr_q <= vic_rr_d;
        end
    end

    // Flush is applied after the fill write so a coincident flush wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (fill_done) valid_q[fill_set][vic_q] <= ~hw_page_fault_i;
            if (mem_fc)    valid_q <= '0;
        end
    end

    // Tag/data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[fill_set][vic_q]  <= addr_q[31:5+SB];
            data_q[fill_set][vic_q] <= data_i;
        end
    end

    assign rd_o            = (state_q == FILL);
    assign addr_o          = addr_q;
    assign hw_page_fault_o = rd_o & ack_i & hw_page_fault_i;
    assign uncached_addr_o = inst_addr_i;
    assign uncached_rd_o   = uncached;
    assign inst_valid_o    = uncached ? uncached_ack_i  : hit;
    assign inst_data_o     = uncached ? uncached_data_i : hit_word;

`ifdef INST_CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (mem_fc) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (state_q == IDLE && state_d == FILL) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end
    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_inst_cache_assoc.sv
// Self-checking bench for inst_cache_assoc (WAYS=2, SETS=64). Expected values
// come from a per-set way table model kept in the bench.
module tb_inst_cache_assoc;

    localparam int WAYS = 2;
    localparam int SETS = 64;
    localparam logic [31:0] PARK = 32'hFFFF_F000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  inst_addr;
    logic [31:0]  inst_data_o;
    logic         inst_valid_o;
    logic         mem_fc;
    logic         hw_page_fault_o;
    logic [31:0]  uncached_addr_o;
    logic [31:0]  uncached_data;
    logic         uncached_rd_o;
    logic         uncached_ack;
    logic [31:0]  addr_o;
    logic [255:0] data;
    logic         rd_o;
    logic         ack;
    logic         pf;

    int checks = 0;
    int errors = 0;

    // Reference model: per set, a table of ways plus a round-robin pointer.
    bit           mv [SETS][WAYS];
    logic [26:0]  mline [SETS][WAYS];
    logic [255:0] md [SETS][WAYS];
    int           mrr [SETS];
    bit           force_w2 = 0;

    always #5 clk = ~clk;

    inst_cache_assoc #(.WAYS(WAYS), .SETS(SETS), .UNCACHED_MASK(32'hFFFF_F000)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_addr_i(inst_addr), .inst_data_o(inst_data_o), .inst_valid_o(inst_valid_o),
        .mem_fc(mem_fc), .hw_page_fault_o(hw_page_fault_o),
        .uncached_addr_o(uncached_addr_o), .uncached_data_i(uncached_data),
        .uncached_rd_o(uncached_rd_o), .uncached_ack_i(uncached_ack),
        .addr_o(addr_o), .data_i(data), .rd_o(rd_o), .ack_i(ack),
        .hw_page_fault_i(pf)
    );

    function automatic int set_of(input logic [31:0] a);
        return int'(a[31:5]) % SETS;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) mv[s][w] = 0;
    endfunction

    function automatic void model_reset();
        model_clear();
        for (int s = 0; s < SETS; s++) mrr[s] = 0;
    endfunction

    function automatic void model_lookup(input logic [31:0] a, output bit h, output logic [31:0] wd);
        int s = set_of(a);
        h = 0; wd = '0;
        for (int w = 0; w < WAYS; w++)
            if (mv[s][w] && mline[s][w] == a[31:5]) begin
                h = 1; wd = md[s][w][a[4:2]*32 +: 32];
            end
    endfunction

    task automatic peek(input logic [31:0] a);
        bit h; logic [31:0] wd;
        @(negedge clk); inst_addr = a; #1;
        model_lookup(a, h, wd);
        checks++; if (inst_valid_o !== h) begin errors++; $display("FAIL peek_valid a=%h got %b exp %b", a, inst_valid_o, h); end
        if (h) begin checks++; if (inst_data_o !== wd) begin errors++; $display("FAIL peek_data a=%h got %h exp %h", a, inst_data_o, wd); end end
        inst_addr = PARK;
    endtask

    // Full fetch: hit check, or miss -> refill with random latency -> recheck.
    task automatic do_fetch(input logic [31:0] a, input bit fault, input bit flush_on_ack);
        bit h; logic [31:0] wd; int s, v, lat; bit byrr; logic [255:0] line;
        @(negedge clk); inst_addr = a; #1;
        model_lookup(a, h, wd);
        checks++; if (inst_valid_o !== h) begin errors++; $display("FAIL fetch_valid a=%h got %b exp %b", a, inst_valid_o, h); end
        if (h) begin
            checks++; if (inst_data_o !== wd) begin errors++; $display("FAIL fetch_data a=%h got %h exp %h", a, inst_data_o, wd); end
            inst_addr = PARK;
            return;
        end
        s = set_of(a); v = -1; byrr = 0;
        for (int w = 0; w < WAYS; w++) if (!mv[s][w] && v < 0) v = w;
        if (v < 0) begin v = mrr[s]; byrr = 1; end
        @(negedge clk); #1;
        checks++; if (rd_o !== 1'b1 || addr_o !== {a[31:5], 5'b0}) begin errors++; $display("FAIL fill_req rd=%b addr=%h exp rd=1 addr=%h", rd_o, addr_o, {a[31:5], 5'b0}); end
        lat = $urandom_range(0, 3);
        repeat (lat) begin
            @(negedge clk); #1;
            checks++; if (rd_o !== 1'b1 || addr_o !== {a[31:5], 5'b0}) begin errors++; $display("FAIL fill_hold rd=%b addr=%h", rd_o, addr_o); end
        end
        for (int k = 0; k < 8; k++) line[k*32 +: 32] = $urandom;
        if (force_w2) line[95:64] = 32'hDEADBEEF;
        data = line; ack = 1; pf = fault; mem_fc = flush_on_ack; #1;
        checks++; if (hw_page_fault_o !== fault) begin errors++; $display("FAIL page_fault got %b exp %b", hw_page_fault_o, fault); end
        @(posedge clk);
        mline[s][v] = a[31:5]; md[s][v] = line; mv[s][v] = !fault;
        if (byrr) mrr[s] = (mrr[s] + 1) % WAYS;
        if (flush_on_ack) model_clear();
        @(negedge clk); ack = 0; pf = 0; mem_fc = 0; #1;
        checks++; if (rd_o !== 1'b0 || addr_o !== 32'h0) begin errors++; $display("FAIL fill_end rd=%b addr=%h exp 0/0", rd_o, addr_o); end
        model_lookup(a, h, wd);
        checks++; if (inst_valid_o !== h) begin errors++; $display("FAIL post_fill_valid a=%h got %b exp %b", a, inst_valid_o, h); end
        if (h) begin checks++; if (inst_data_o !== wd) begin errors++; $display("FAIL post_fill_data a=%h got %h exp %h", a, inst_data_o, wd); end end
        inst_addr = PARK;
    endtask

    task automatic flush();
        @(negedge clk); inst_addr = PARK; mem_fc = 1;
        @(negedge clk); mem_fc = 0;
        model_clear();
    endtask

    task automatic test_reset();
        @(negedge clk); inst_addr = 32'h0000_0100; #1;
        checks++; if (rd_o !== 1'b0 || addr_o !== 32'h0) begin errors++; $display("FAIL reset_out rd=%b addr=%h", rd_o, addr_o); end
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", inst_valid_o); end
        inst_addr = PARK;
        @(negedge clk); rst_n = 1;
        model_reset();
    endtask

    task automatic test_basic();
        force_w2 = 1;
        do_fetch(32'h0000_0100, 0, 0);
        force_w2 = 0;
        @(negedge clk); inst_addr = 32'h0000_0108; #1;
        checks++; if (inst_valid_o !== 1'b1 || inst_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_word2 v=%b d=%h exp 1 deadbeef", inst_valid_o, inst_data_o); end
        inst_addr = PARK;
        do_fetch(32'h0000_0108, 0, 0);
    endtask

    task automatic test_eviction();
        bit h; logic [31:0] wd;
        flush();
        do_fetch(32'h0000_0000, 0, 0);
        do_fetch(32'h0000_0800, 0, 0);
        do_fetch(32'h0000_0004, 0, 0);
        do_fetch(32'h0000_0804, 0, 0);
        do_fetch(32'h0000_1000, 0, 0);
        model_lookup(32'h0000_0000, h, wd);
        @(negedge clk); inst_addr = 32'h0000_0000; #1;
        checks++; if (inst_valid_o !== 1'b0 || h) begin errors++; $display("FAIL evict_way0 got %b exp 0", inst_valid_o); end
        inst_addr = PARK;
        peek(32'h0000_0800);
        peek(32'h0000_1000);
    endtask

    task automatic test_uncached();
        @(negedge clk); inst_addr = 32'hFFFF_F004; uncached_ack = 0; uncached_data = 32'h12345678; #1;
        checks++; if (uncached_rd_o !== 1'b1 || uncached_addr_o !== 32'hFFFF_F004 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL unc_req rd=%b a=%h v=%b", uncached_rd_o, uncached_addr_o, inst_valid_o); end
        @(negedge clk); uncached_ack = 1; #1;
        checks++; if (inst_valid_o !== 1'b1 || inst_data_o !== 32'h12345678) begin errors++; $display("FAIL unc_data v=%b d=%h exp 1 12345678", inst_valid_o, inst_data_o); end
        @(negedge clk); uncached_ack = 0; #1;
        checks++; if (rd_o !== 1'b0) begin errors++; $display("FAIL unc_no_fill rd=%b exp 0", rd_o); end
        inst_addr = PARK;
    endtask

    task automatic test_fault();
        do_fetch(32'h0000_0240, 1, 0);
        peek(32'h0000_0240);
        do_fetch(32'h0000_0240, 0, 0);
        peek(32'h0000_0244);
    endtask

    task automatic test_flush();
        do_fetch(32'h0000_0020, 0, 0);
        do_fetch(32'h0000_0040, 0, 0);
        do_fetch(32'h0000_0060, 0, 1);
        peek(32'h0000_0060);
        peek(32'h0000_0020);
        peek(32'h0000_0040);
    endtask

    task automatic test_reset_mid_fill();
        @(negedge clk); inst_addr = 32'h0000_0300;
        @(negedge clk); #1;
        checks++; if (rd_o !== 1'b1 || addr_o !== 32'h0000_0300) begin errors++; $display("FAIL midrst_req rd=%b addr=%h", rd_o, addr_o); end
        rst_n = 0; #1;
        checks++; if (rd_o !== 1'b0 || addr_o !== 32'h0) begin errors++; $display("FAIL midrst_drop rd=%b addr=%h exp 0/0", rd_o, addr_o); end
        model_reset();
        ack = 1;
        @(negedge clk); ack = 0; #1;
        checks++; if (rd_o !== 1'b0) begin errors++; $display("FAIL midrst_ack_ignored rd=%b", rd_o); end
        rst_n = 1;
        @(negedge clk); #1;
        checks++; if (rd_o !== 1'b1 || addr_o !== 32'h0000_0300) begin errors++; $display("FAIL midrst_reissue rd=%b addr=%h", rd_o, addr_o); end
        inst_addr = PARK; rst_n = 0; #1; rst_n = 1;
        model_reset();
    endtask

    task automatic test_random();
        logic [31:0] a; int r;
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 99);
            a = ($urandom_range(0, 3) << 11) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
            if (r < 5) flush();
            else if (r < 12) begin
                @(negedge clk); inst_addr = PARK | ($urandom_range(0, 1023) << 2);
                uncached_data = $urandom; uncached_ack = 1; #1;
                checks++; if (inst_valid_o !== 1'b1 || inst_data_o !== uncached_data) begin errors++; $display("FAIL rand_unc v=%b d=%h exp %h", inst_valid_o, inst_data_o, uncached_data); end
                @(negedge clk); uncached_ack = 0; inst_addr = PARK;
            end
            else do_fetch(a, r >= 92, r >= 88 && r < 92);
        end
    endtask

    initial begin
        rst_n = 0; inst_addr = PARK; mem_fc = 0; uncached_data = '0; uncached_ack = 0;
        data = '0; ack = 0; pf = 0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_eviction();
        test_uncached();
        test_fault();
        test_flush();
        test_reset_mid_fill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
